// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite word-addressed memory slave: programmable wait states, two-cycle ERROR
// response, little-endian byte-lane writes and combinational read in the ACCESS cycle.
module ahb_lite_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_ERR1   = 3'd3;
    localparam logic [2:0] ST_ERR2   = 3'd4;

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [3:0]            cnt_reg;
    logic [3:0]            cnt_next;
    logic [IDX_W+1:0]      addr_q;
    logic                  write_q;
    logic [2:0]            size_q;

    logic                  trans_active;
    logic                  accept;
    logic                  addr_oor;
    logic                  misaligned;
    logic                  bad_size;
    logic                  illegal;
    logic                  capture;
    logic                  commit;
    logic [NUM_LANES-1:0]  lane_en;
    logic [IDX_W-1:0]      word_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // NONSEQ and SEQ are the only transfer types that start a data phase.
    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign accept       = HSEL && HREADY && trans_active;

    // Depth is a power of two, so any set bit above the index field is out of range.
    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
            assign addr_oor = |HADDR[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    assign bad_size   = (HSIZE > 3'd2);
    assign misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign illegal    = bad_size || misaligned || addr_oor;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = ST_ACCESS;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
            default: begin
                // IDLE, ACCESS and ERR2 all present HREADYOUT=1, so a new address phase may land here.
                state_next = ST_IDLE;
                if (accept) begin
                    capture = 1'b1;
                    if (illegal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                addr_q  <= HADDR[IDX_W+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    assign word_q = addr_q[IDX_W+1:2];
    assign commit = (state_reg == ST_ACCESS) && write_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (size_q == 3'd2) ||
                                 ((size_q == 3'd1) && (addr_q[1] == LANE[1])) ||
                                 ((size_q == 3'd0) && (addr_q[1:0] == LANE));
        end
    endgenerate

    // Storage is intentionally not reset; contents are undefined until written.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (lane_en[b]) begin
                    mem[word_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign HRDATA    = ((state_reg == ST_ACCESS) && !write_q) ? mem[word_q] : '0;
    assign HREADYOUT = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
    assign HRESP     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

endmodule
